// File: rtl/syn_sram_arb_if.sv
// Purpose: client request/ack ports and SRAM pin bundle for syn_sram_arb.
// Latency: none; this file only declares wires.
// Backpressure: a client holds req until its ack; the arbiter never stalls an ack.
interface syn_sram_arb_if;
    logic        a_req;
    logic        a_wr;
    logic [17:0] a_addr;
    logic [15:0] a_wdata;
    logic [1:0]  a_be;
    logic        a_ack;
    logic [15:0] a_rdata;

    logic        b_req;
    logic        b_wr;
    logic [17:0] b_addr;
    logic [15:0] b_wdata;
    logic [1:0]  b_be;
    logic        b_ack;
    logic [15:0] b_rdata;

    logic [17:0] SRAM_ADDR;
    logic        SRAM_LB_N;
    logic        SRAM_UB_N;
    logic        SRAM_CE_N;
    logic        SRAM_OE_N;
    logic        SRAM_WE_N;
    logic [15:0] SRAM_DO;
    logic [15:0] SRAM_DI;

    // Arbiter side: takes client requests, drives the SRAM pins.
    modport mp (
        input  a_req, a_wr, a_addr, a_wdata, a_be,
        output a_ack, a_rdata,
        input  b_req, b_wr, b_addr, b_wdata, b_be,
        output b_ack, b_rdata,
        output SRAM_ADDR, SRAM_LB_N, SRAM_UB_N, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_DO,
        input  SRAM_DI
    );

    // Environment side: clients plus the SRAM device.
    modport sp (
        output a_req, a_wr, a_addr, a_wdata, a_be,
        input  a_ack, a_rdata,
        output b_req, b_wr, b_addr, b_wdata, b_be,
        input  b_ack, b_rdata,
        input  SRAM_ADDR, SRAM_LB_N, SRAM_UB_N, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_DO,
        output SRAM_DI
    );
endinterface

// File: rtl/syn_sram_arb.sv
// Purpose: round-robin two-client arbiter/sequencer for the 256Kx16 async SRAM; SYN_SRAM_ARB_STATS_EN adds ack counters.
// Latency: strobes N+1..N+WAIT_CYCLES after the sampling edge N, ack at N+WAIT_CYCLES+1.
// Backpressure: requests are sampled only in IDLE; a client waits (req held) until its one-cycle ack.
module syn_sram_arb #(
    parameter int WAIT_CYCLES = 1,
    parameter int CNTR_W      = 16
) (
    input  logic              clk_ir,
    input  logic              rst_il,
    syn_sram_arb_if.mp        bus
`ifdef SYN_SRAM_ARB_STATS_EN
    ,
    input  logic              stats_clr,
    output logic [CNTR_W-1:0] a_cnt,
    output logic [CNTR_W-1:0] b_cnt
`endif
);

    localparam int WCW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    generate
        if (WAIT_CYCLES < 1) begin : g_bad_wait
            $error("syn_sram_arb: WAIT_CYCLES must be >= 1");
        end
        if (CNTR_W < 1) begin : g_bad_cntr
            $error("syn_sram_arb: CNTR_W must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RECOVER = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [WCW-1:0]  wait_cnt;
    logic            last_b;     // 1 = B was granted most recently
    logic            sel_b;      // owner of the access in flight
    logic            sel_wr;     // direction of the access in flight
    logic            gnt_a;
    logic            gnt_b;
    logic            wait_done;
    logic            req_wr;
    logic [17:0]     req_addr;
    logic [15:0]     req_wdata;
    logic [1:0]      req_be;

    // Round-robin pick and mux of the winner's request fields.
    always_comb begin
        gnt_a     = bus.a_req & (~bus.b_req | last_b);
        gnt_b     = bus.b_req & ~gnt_a;
        req_wr    = gnt_b ? bus.b_wr    : bus.a_wr;
        req_addr  = gnt_b ? bus.b_addr  : bus.a_addr;
        req_wdata = gnt_b ? bus.b_wdata : bus.a_wdata;
        req_be    = gnt_b ? bus.b_be    : bus.a_be;
        wait_done = (wait_cnt == WCW'(WAIT_CYCLES - 1));
    end

    // State register.
    always_ff @(posedge clk_ir) begin
        if (rst_il) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt_a | gnt_b) state_nxt = ACCESS;
            ACCESS:  if (wait_done)     state_nxt = RECOVER;
            RECOVER: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Registered SRAM pins, acks, read data and grant bookkeeping.
    always_ff @(posedge clk_ir) begin
        if (rst_il) begin
            bus.SRAM_ADDR <= '0;
            bus.SRAM_DO   <= '0;
            bus.SRAM_CE_N <= 1'b1;
            bus.SRAM_OE_N <= 1'b1;
            bus.SRAM_WE_N <= 1'b1;
            bus.SRAM_LB_N <= 1'b1;
            bus.SRAM_UB_N <= 1'b1;
            bus.a_ack     <= 1'b0;
            bus.b_ack     <= 1'b0;
            bus.a_rdata   <= '0;
            bus.b_rdata   <= '0;
            last_b        <= 1'b1;
            sel_b         <= 1'b0;
            sel_wr        <= 1'b0;
            wait_cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.a_ack <= 1'b0;
                    bus.b_ack <= 1'b0;
                    if (gnt_a | gnt_b) begin
                        sel_b         <= gnt_b;
                        sel_wr        <= req_wr;
                        last_b        <= gnt_b;
                        wait_cnt      <= '0;
                        bus.SRAM_ADDR <= req_addr;
                        bus.SRAM_CE_N <= 1'b0;
                        bus.SRAM_LB_N <= ~req_be[0];
                        bus.SRAM_UB_N <= ~req_be[1];
                        if (req_wr) begin
                            bus.SRAM_DO   <= req_wdata;
                            bus.SRAM_WE_N <= 1'b0;
                        end else begin
                            bus.SRAM_OE_N <= 1'b0;
                        end
                    end
                end
                ACCESS: begin
                    if (wait_done) begin
                        // Data is sampled while OE_N is still low, then strobes release.
                        if (!sel_wr) begin
                            if (sel_b) bus.b_rdata <= bus.SRAM_DI;
                            else       bus.a_rdata <= bus.SRAM_DI;
                        end
                        bus.SRAM_WE_N <= 1'b1;
                        bus.SRAM_OE_N <= 1'b1;
                        bus.a_ack     <= ~sel_b;
                        bus.b_ack     <= sel_b;
                    end else begin
                        wait_cnt <= wait_cnt + WCW'(1);
                    end
                end
                RECOVER: begin
                    // Address and data are left untouched to avoid needless bus toggling.
                    bus.a_ack     <= 1'b0;
                    bus.b_ack     <= 1'b0;
                    bus.SRAM_CE_N <= 1'b1;
                    bus.SRAM_LB_N <= 1'b1;
                    bus.SRAM_UB_N <= 1'b1;
                end
                default: begin
                    bus.a_ack <= 1'b0;
                    bus.b_ack <= 1'b0;
                end
            endcase
        end
    end

`ifdef SYN_SRAM_ARB_STATS_EN
    // Saturating per-client ack counters; clear beats a same-cycle increment.
    always_ff @(posedge clk_ir) begin
        if (rst_il || stats_clr) begin
            a_cnt <= '0;
            b_cnt <= '0;
        end else begin
            if (bus.a_ack && (a_cnt != '1)) a_cnt <= a_cnt + CNTR_W'(1);
            if (bus.b_ack && (b_cnt != '1)) b_cnt <= b_cnt + CNTR_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_syn_sram_arb.sv
// Purpose: directed self-checking bench for syn_sram_arb (WAIT_CYCLES=1 and 3 instances, small SRAM model).
// Latency: checks strobe windows and ack timing cycle by cycle.
// Backpressure: clients hold req until ack, drop it in the ack cycle.
module tb_syn_sram_arb;

    logic clk_ir = 1'b0;
    logic rst_il;
    logic rst3;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk_ir = ~clk_ir;

    syn_sram_arb_if sif ();
    syn_sram_arb_if sif3 ();

`ifdef SYN_SRAM_ARB_STATS_EN
    localparam int TB_CW = 4;
    logic       stats_clr;
    logic [3:0] a_cnt, b_cnt, a_cnt3, b_cnt3;
`else
    localparam int TB_CW = 16;
`endif

    syn_sram_arb #(.WAIT_CYCLES(1), .CNTR_W(TB_CW)) u_dut (
        .clk_ir    (clk_ir),
        .rst_il    (rst_il),
        .bus       (sif)
`ifdef SYN_SRAM_ARB_STATS_EN
        ,
        .stats_clr (stats_clr),
        .a_cnt     (a_cnt),
        .b_cnt     (b_cnt)
`endif
    );

    syn_sram_arb #(.WAIT_CYCLES(3), .CNTR_W(TB_CW)) u_dut3 (
        .clk_ir    (clk_ir),
        .rst_il    (rst3),
        .bus       (sif3)
`ifdef SYN_SRAM_ARB_STATS_EN
        ,
        .stats_clr (1'b0),
        .a_cnt     (a_cnt3),
        .b_cnt     (b_cnt3)
`endif
    );

    // SRAM model: 16 words addressed by ADDR[3:0], preset to i*0x1111 on reset.
    logic [15:0] mem [0:15];
    always @(posedge clk_ir) begin
        if (rst_il) begin
            for (int i = 0; i < 16; i++) mem[i] <= 16'(i * 16'h1111);
        end else if (!sif.SRAM_CE_N && !sif.SRAM_WE_N) begin
            if (!sif.SRAM_LB_N) mem[sif.SRAM_ADDR[3:0]][7:0]  <= sif.SRAM_DO[7:0];
            if (!sif.SRAM_UB_N) mem[sif.SRAM_ADDR[3:0]][15:8] <= sif.SRAM_DO[15:8];
        end
    end
    assign sif.SRAM_DI  = sif.SRAM_OE_N  ? 16'h0000 : mem[sif.SRAM_ADDR[3:0]];
    assign sif3.SRAM_DI = sif3.SRAM_OE_N ? 16'h0000 : mem[sif3.SRAM_ADDR[3:0]];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_ir);
        @(negedge clk_ir);
    endtask

    task automatic issue(input logic cli_b, input logic wr, input logic [17:0] addr,
                         input logic [15:0] wd, input logic [1:0] be);
        if (cli_b) begin
            sif.b_req = 1'b1; sif.b_wr = wr; sif.b_addr = addr; sif.b_wdata = wd; sif.b_be = be;
        end else begin
            sif.a_req = 1'b1; sif.a_wr = wr; sif.a_addr = addr; sif.a_wdata = wd; sif.a_be = be;
        end
    endtask

    task automatic drop();
        sif.a_req = 1'b0;
        sif.b_req = 1'b0;
    endtask

    function automatic logic [4:0] strobes(input logic ce, oe, we, lb, ub);
        return {ce, oe, we, lb, ub};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int bad;
        int n;
        rst_il = 1'b1;
        rst3   = 1'b1;
        drop();
        sif.a_wr = 0; sif.a_addr = 0; sif.a_wdata = 0; sif.a_be = 0;
        sif.b_wr = 0; sif.b_addr = 0; sif.b_wdata = 0; sif.b_be = 0;
        sif3.a_req = 0; sif3.a_wr = 0; sif3.a_addr = 0; sif3.a_wdata = 0; sif3.a_be = 0;
        sif3.b_req = 0; sif3.b_wr = 0; sif3.b_addr = 0; sif3.b_wdata = 0; sif3.b_be = 0;
`ifdef SYN_SRAM_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        step(); step(); step();

        // Reset values.
        chk("rst_strobes", strobes(sif.SRAM_CE_N, sif.SRAM_OE_N, sif.SRAM_WE_N, sif.SRAM_LB_N, sif.SRAM_UB_N), 5'b11111);
        chk("rst_addr", sif.SRAM_ADDR, 0);
        chk("rst_do", sif.SRAM_DO, 0);
        chk("rst_acks", {sif.a_ack, sif.b_ack}, 0);
        chk("rst_rdata", {sif.a_rdata, sif.b_rdata}, 0);
        chk("rst3_strobes", strobes(sif3.SRAM_CE_N, sif3.SRAM_OE_N, sif3.SRAM_WE_N, sif3.SRAM_LB_N, sif3.SRAM_UB_N), 5'b11111);
        rst_il = 1'b0;
        rst3   = 1'b0;

        // A write, full word.
        issue(0, 1, 18'h12345, 16'hBEEF, 2'b11);
        step();
        chk("wr_strobes", strobes(sif.SRAM_CE_N, sif.SRAM_OE_N, sif.SRAM_WE_N, sif.SRAM_LB_N, sif.SRAM_UB_N), 5'b01000);
        chk("wr_addr", sif.SRAM_ADDR, 32'h12345);
        chk("wr_do", sif.SRAM_DO, 32'hBEEF);
        chk("wr_ack_early", sif.a_ack, 0);
        step();
        chk("wr_strobes_rec", strobes(sif.SRAM_CE_N, sif.SRAM_OE_N, sif.SRAM_WE_N, sif.SRAM_LB_N, sif.SRAM_UB_N), 5'b01100);
        chk("wr_ack", {sif.a_ack, sif.b_ack}, 2'b10);
        drop();
        step();
        chk("wr_ack_pulse", sif.a_ack, 0);
        chk("wr_idle_strobes", strobes(sif.SRAM_CE_N, sif.SRAM_OE_N, sif.SRAM_WE_N, sif.SRAM_LB_N, sif.SRAM_UB_N), 5'b11111);
        chk("wr_addr_held", sif.SRAM_ADDR, 32'h12345);
        chk("wr_mem", mem[5], 32'hBEEF);

        // A read back.
        issue(0, 0, 18'h12345, 16'h0, 2'b11);
        step();
        chk("rd_strobes", strobes(sif.SRAM_CE_N, sif.SRAM_OE_N, sif.SRAM_WE_N, sif.SRAM_LB_N, sif.SRAM_UB_N), 5'b00100);
        step();
        chk("rd_ack", {sif.a_ack, sif.b_ack}, 2'b10);
        chk("rd_data", sif.a_rdata, 32'hBEEF);
        chk("rd_oe_rel", sif.SRAM_OE_N, 1);
        drop();
        step();

        // be=00 write: full cycle, both masks high, nothing changes.
        issue(0, 1, 18'h12345, 16'h0000, 2'b00);
        step();
        chk("be0_strobes", strobes(sif.SRAM_CE_N, sif.SRAM_OE_N, sif.SRAM_WE_N, sif.SRAM_LB_N, sif.SRAM_UB_N), 5'b01011);
        step();
        chk("be0_ack", sif.a_ack, 1);
        chk("be0_rdata_kept", sif.a_rdata, 32'hBEEF);
        drop();
        step();
        chk("be0_mem", mem[5], 32'hBEEF);

        // Contention from reset: strict alternation A,B,... one ack every 3 cycles.
        rst_il = 1'b1;
        step(); step();
        rst_il = 1'b0;
        issue(0, 0, 18'h00001, 16'h0, 2'b11);
        issue(1, 0, 18'h00002, 16'h0, 2'b11);
        k   = 0;
        bad = 0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (sif.a_ack && sif.b_ack) bad++;
            if (sif.a_ack || sif.b_ack) begin
                if (k < 8) begin
                    chk("cont_who_b", sif.b_ack, k % 2);
                    chk("cont_cycle", c, 1 + 3 * k);
                end
                if (k == 6) sif.a_req = 1'b0;
                if (k == 7) sif.b_req = 1'b0;
                k++;
            end
        end
        chk("cont_count", k, 8);
        chk("cont_both_acks", bad, 0);
        chk("cont_a_rdata", sif.a_rdata, 32'h1111);
        chk("cont_b_rdata", sif.b_rdata, 32'h2222);

        // B upper-byte write, then A readback.
        issue(1, 1, 18'h12345, 16'h00FF, 2'b10);
        step();
        chk("bw_strobes", strobes(sif.SRAM_CE_N, sif.SRAM_OE_N, sif.SRAM_WE_N, sif.SRAM_LB_N, sif.SRAM_UB_N), 5'b01010);
        step();
        chk("bw_ack", {sif.a_ack, sif.b_ack}, 2'b01);
        chk("bw_rdata_kept", sif.b_rdata, 32'h2222);
        drop();
        step();
        issue(0, 0, 18'h12345, 16'h0, 2'b11);
        step(); step();
        chk("bw_readback_ack", sif.a_ack, 1);
        chk("bw_readback", sif.a_rdata, 32'h0055);
        drop();
        step();

        // WAIT_CYCLES=3: complete read with a 3-cycle strobe window.
        sif3.a_req = 1'b1; sif3.a_wr = 1'b0; sif3.a_addr = 18'h12345; sif3.a_be = 2'b11;
        n = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (!sif3.SRAM_OE_N && !sif3.a_ack) n++;
        end
        chk("w3_oe_cycles", n, 3);
        step();
        chk("w3_ack", sif3.a_ack, 1);
        chk("w3_rdata", sif3.a_rdata, 32'h0055);
        sif3.a_req = 1'b0;
        step();

        // WAIT_CYCLES=3: reset during the 2nd ACCESS cycle drops the access.
        sif3.a_req = 1'b1; sif3.a_addr = 18'h00002;
        step(); step();
        chk("w3_mid_oe", sif3.SRAM_OE_N, 0);
        rst3 = 1'b1;
        sif3.a_req = 1'b0;
        step();
        chk("w3_rst_strobes", strobes(sif3.SRAM_CE_N, sif3.SRAM_OE_N, sif3.SRAM_WE_N, sif3.SRAM_LB_N, sif3.SRAM_UB_N), 5'b11111);
        chk("w3_rst_addr", sif3.SRAM_ADDR, 0);
        chk("w3_rst_ack", sif3.a_ack, 0);
        rst3 = 1'b0;
        n = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (sif3.a_ack || sif3.b_ack) n++;
        end
        chk("w3_no_ack_after_rst", n, 0);
        chk("w3_rdata_rst", sif3.a_rdata, 0);
        sif3.a_req = 1'b1;
        step(); step(); step(); step();
        chk("w3_post_rst_ack", sif3.a_ack, 1);
        chk("w3_post_rst_rdata", sif3.a_rdata, 32'h2222);
        sif3.a_req = 1'b0;
        step();

`ifdef SYN_SRAM_ARB_STATS_EN
        // Counters: saturation at 15, clear wins over a same-cycle ack.
        chk("st_cnt3", a_cnt3, 1);
        stats_clr = 1'b1;
        step();
        stats_clr = 1'b0;
        chk("st_clr", a_cnt, 0);
        issue(0, 0, 18'h00001, 16'h0, 2'b11);
        k = 0;
        for (int c = 0; c < 70 && k < 17; c++) begin
            step();
            if (sif.a_ack) k++;
        end
        drop();
        step();
        chk("st_acks", k, 17);
        chk("st_sat", a_cnt, 15);
        chk("st_b_cnt", b_cnt, 0);
        issue(0, 0, 18'h00001, 16'h0, 2'b11);
        step(); step();
        chk("st_clr_ack", sif.a_ack, 1);
        stats_clr = 1'b1;
        drop();
        step();
        stats_clr = 1'b0;
        chk("st_clr_wins", a_cnt, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
